comparator_bist: RTL and testbench
==================================

# comparator_bist

Synthesizable built-in self-test driver/checker for the `comparator_2bit` interface. It sweeps every (A, B) operand pair into a comparator under test and samples the GT/EQ/LT outputs after a programmable settle time. Each sample is checked against an internal reference model, and the block reports an error count and a pass flag. It sits beside any comparator instance on the test/debug path and replaces a simulation-only exhaustive bench with hardware.

## Interface
- WIDTH, 2, operand width; sweep covers 2^(2*WIDTH) vectors
- SETTLE, 1, cycles each vector is held before sampling (must be >= 1)
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  begin sweep; sampled in IDLE or DONE only
- dut_a  out  WIDTH  operand A driven to the comparator
- dut_b  out  WIDTH  operand B driven to the comparator
- dut_gt / dut_eq / dut_lt  in  1 each  comparator outputs
- busy  out  1  sweep in progress
- done  out  1  sweep finished; held until next start or rst
- pass  out  1  valid when done; 1 iff err_count == 0
- err_count  out  2*WIDTH+1  number of failing vectors (cannot overflow)

## Operation
- Vector index idx, 2*WIDTH bits; dut_a = idx[2W-1:W], dut_b = idx[W-1:0]. A is the outer loop and B the inner loop, so for W=2 the order is (0,0),(0,1)…(3,3).
- Expected result, unsigned: gt = a>b, eq = a==b, lt = a<b, computed by the reference model.
- A vector fails if any of {gt,eq,lt} differs from expected. Non-one-hot outputs therefore always fail.
- FSM states:
  - IDLE: start → DRIVE; idx=0, err_count=0.
  - DRIVE: hold the vector for SETTLE cycles (settle counter), then → CHECK.
  - CHECK: one cycle. Compare the observed outputs and increment err_count on mismatch. If idx is the last vector → DONE, otherwise idx+1 → DRIVE.
  - DONE: done=1, pass valid. start → DRIVE with idx=0 and err_count cleared. Without start, the block stays in DONE.
- start in DRIVE or CHECK is ignored.
- busy=1 in DRIVE and CHECK. done=1 only in DONE.
- dut_a and dut_b are registered. They change only on the DRIVE entry edge.

## Timing
- Reset values: state IDLE, dut_a=0, dut_b=0, busy=0, done=0, pass=0, err_count=0.
- Rst mid-sweep aborts immediately at the next edge, returning all outputs to reset values. There is no partial result.
- Start is accepted on edge E. busy=1 and dut_a/dut_b hold vector 0 from E.
- Per vector: SETTLE+1 cycles. Sampling happens at the edge that ends CHECK.
- done rises exactly 2^(2W)*(SETTLE+1) cycles after E; for W=2, SETTLE=1 that is 32 cycles.
- err_count updates one edge after each CHECK. The final value is stable when done rises.
- Start on the same edge as rst: rst wins.

## Configuration
- COMPARATOR_BIST_FAIL_LOG_EN defined:
  - Adds fail_valid (1), fail_a (WIDTH), fail_b (WIDTH) and fail_obs (3, {gt,eq,lt}) outputs.
  - These capture the first failing vector of a sweep. They reset to 0 and clear on start.
  - Later failures do not overwrite them.
- Undefined: these ports and their registers are absent. All other behaviour is identical.

## Structure
- comparator_bist_pkg:
  - state_t enum {IDLE, DRIVE, CHECK, DONE}
  - cmp_result_t packed struct {gt, eq, lt}
  - compare function or constant helpers for vector count
- Sub-module comparator_ref: combinational reference model, parameterized WIDTH, output cmp_result_t. This is the only child instance.

## Test plan
- Correct comparator_2bit, W=2, SETTLE=1, pulse start → done at +32 cycles, err_count=0, pass=1, busy low after.
- DUT with eq stuck at 1 (gt/lt correct) → err_count=12, pass=0.
- DUT with gt/lt swapped → err_count=12. With FAIL_LOG_EN: fail_valid=1, fail_a=0, fail_b=1, fail_obs=3'b100.
- Reset asserted at cycle 10 of a sweep → next cycle all outputs at reset values. A fresh start completes 32 cycles later with pass=1.
- start pulsed mid-sweep → ignored, done still at +32. start in DONE → done drops next edge, err_count=0, sweep repeats with identical result.
- SETTLE=3 with correct DUT → done at +64 cycles. dut_a/dut_b each stable for 4 cycles, pass=1.

Source files
------------

// File: rtl/comparator_bist_pkg.sv
// comparator_bist_pkg
// Shared types and helpers for the comparator BIST:
//   state_t      - sweep controller states
//   cmp_result_t - {gt, eq, lt} comparator result bundle
//   vec_count()  - number of (A, B) vectors swept for a given operand width
package comparator_bist_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef struct packed {
    logic gt;
    logic eq;
    logic lt;
  } cmp_result_t;

  // Every (A, B) pair of two width-bit operands.
  function automatic int unsigned vec_count(input int unsigned width);
    return 32'd1 << (32'd2 * width);
  endfunction

endpackage

// File: rtl/comparator_ref.sv
// comparator_ref
// Combinational golden model of an unsigned magnitude comparator.
// Ports:
//   a, b   in  WIDTH  operands
//   result out 3      {gt, eq, lt}, exactly one bit set
module comparator_ref
  import comparator_bist_pkg::*;
#(
  parameter int WIDTH = 2
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output cmp_result_t      result
);

  // Unsigned compare of the two operands.
  always_comb begin
    result.gt = (a > b);
    result.eq = (a == b);
    result.lt = (a < b);
  end

endmodule

// File: rtl/comparator_bist.sv
// comparator_bist
// Exhaustive built-in self-test for a WIDTH-bit magnitude comparator.
// Sweeps every (A, B) pair (A outer, B inner), holds each vector SETTLE
// cycles, samples {gt, eq, lt} in a one-cycle CHECK state and counts
// vectors whose outputs differ from the reference model.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start               begin a sweep (honoured only in IDLE or DONE)
//   dut_a, dut_b        registered operands to the comparator under test
//   dut_gt/eq/lt        comparator outputs under test
//   busy, done, pass    status; pass is meaningful while done is high
//   err_count           number of failing vectors in the sweep
// Optional (macro COMPARATOR_BIST_FAIL_LOG_EN):
//   fail_valid, fail_a, fail_b, fail_obs  first failing vector of the sweep
module comparator_bist
  import comparator_bist_pkg::*;
#(
  parameter int WIDTH  = 2,
  parameter int SETTLE = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic [WIDTH-1:0]   dut_a,
  output logic [WIDTH-1:0]   dut_b,
  input  logic               dut_gt,
  input  logic               dut_eq,
  input  logic               dut_lt,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [2*WIDTH:0]   err_count
`ifdef COMPARATOR_BIST_FAIL_LOG_EN
  ,
  output logic               fail_valid,
  output logic [WIDTH-1:0]   fail_a,
  output logic [WIDTH-1:0]   fail_b,
  output logic [2:0]         fail_obs
`endif
);

  localparam int IW = 2 * WIDTH;
  localparam int EW = IW + 1;
  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE - 1);
  localparam logic [IW-1:0] IDX_LAST    = IW'(vec_count(WIDTH) - 1);

  state_t        state;
  state_t        state_next;
  logic [IW-1:0] idx;
  logic [IW-1:0] idx_next;
  logic [CW-1:0] settle_cnt;
  logic [CW-1:0] settle_cnt_next;
  logic [EW-1:0] err_next;
  logic          start_accept;
  logic          mismatch;
  cmp_result_t   expected;
  cmp_result_t   observed;

  // The operand registers are simply the two halves of the vector index.
  assign dut_a = idx[IW-1:WIDTH];
  assign dut_b = idx[WIDTH-1:0];

  assign observed     = '{gt: dut_gt, eq: dut_eq, lt: dut_lt};
  assign start_accept = start && ((state == IDLE) || (state == DONE));
  // Any differing bit fails, so non-one-hot outputs can never pass.
  assign mismatch     = (observed != expected);

  comparator_ref #(
    .WIDTH (WIDTH)
  ) u_ref (
    .a      (dut_a),
    .b      (dut_b),
    .result (expected)
  );

  // Sweep sequencing: next state, vector index, settle counter, error count.
  always_comb begin
    state_next      = state;
    idx_next        = idx;
    settle_cnt_next = settle_cnt;
    err_next        = err_count;
    case (state)
      IDLE, DONE: begin
        if (start_accept) begin
          state_next      = DRIVE;
          idx_next        = {IW{1'b0}};
          settle_cnt_next = {CW{1'b0}};
          err_next        = {EW{1'b0}};
        end else begin
          state_next = state;
        end
      end
      DRIVE: begin
        if (settle_cnt == SETTLE_LAST) begin
          state_next = CHECK;
        end else begin
          settle_cnt_next = settle_cnt + CW'(1);
        end
      end
      CHECK: begin
        if (mismatch) begin
          err_next = err_count + EW'(1);
        end else begin
          err_next = err_count;
        end
        if (idx == IDX_LAST) begin
          state_next = DONE;
        end else begin
          state_next      = DRIVE;
          idx_next        = idx + IW'(1);
          settle_cnt_next = {CW{1'b0}};
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Controller state and registered status outputs, derived from next state
  // so they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      idx        <= {IW{1'b0}};
      settle_cnt <= {CW{1'b0}};
      err_count  <= {EW{1'b0}};
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
    end else begin
      state      <= state_next;
      idx        <= idx_next;
      settle_cnt <= settle_cnt_next;
      err_count  <= err_next;
      busy       <= (state_next == DRIVE) || (state_next == CHECK);
      done       <= (state_next == DONE);
      pass       <= (state_next == DONE) && (err_next == {EW{1'b0}});
    end
  end

`ifdef COMPARATOR_BIST_FAIL_LOG_EN
  // First-failure capture; later failures in the same sweep are ignored.
  always_ff @(posedge clk) begin
    if (rst || start_accept) begin
      fail_valid <= 1'b0;
      fail_a     <= {WIDTH{1'b0}};
      fail_b     <= {WIDTH{1'b0}};
      fail_obs   <= 3'b000;
    end else if ((state == CHECK) && mismatch && !fail_valid) begin
      fail_valid <= 1'b1;
      fail_a     <= dut_a;
      fail_b     <= dut_b;
      fail_obs   <= observed;
    end else begin
      fail_valid <= fail_valid;
      fail_a     <= fail_a;
      fail_b     <= fail_b;
      fail_obs   <= fail_obs;
    end
  end
`endif

endmodule

// File: tb/tb_comparator_bist.sv
// tb_comparator_bist
// Bench for comparator_bist. Instance u_dut0 (SETTLE=1) faces a behavioural
// comparator whose behaviour is selected by mode0 (correct, eq stuck at 1,
// gt/lt swapped, random per-vector fault table). Instance u_dut1 (SETTLE=3)
// faces a correct comparator. Expected error counts and first failures come
// from a sweep over all operand pairs in plain arithmetic.
module tb_comparator_bist;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst0, start0, gt0, eq0, lt0, busy0, done0, pass0;
  logic [1:0] a0, b0;
  logic [4:0] err0;
  logic       rst1, start1, gt1, eq1, lt1, busy1, done1, pass1;
  logic [1:0] a1, b1;
  logic [4:0] err1;
`ifdef COMPARATOR_BIST_FAIL_LOG_EN
  logic       fv0, fv1;
  logic [1:0] fa0, fb0, fa1, fb1;
  logic [2:0] fo0, fo1;
`endif

  int         mode0;
  logic [2:0] fault_tbl [16];
  int         checks = 0;
  int         passed = 0;

  function automatic logic [2:0] true_cmp(input int a, input int b);
    return {a > b, a == b, a < b};
  endfunction

  // Comparator behaviour under test: 0 good, 1 eq stuck-1, 2 gt/lt swapped, 3 xor fault mask.
  function automatic logic [2:0] obs_fn(input int mode, input int a, input int b, input logic [2:0] mask);
    logic [2:0] t;
    t = true_cmp(a, b);
    case (mode)
      1:       return {t[2], 1'b1, t[0]};
      2:       return {t[0], t[1], t[2]};
      3:       return t ^ mask;
      default: return t;
    endcase
  endfunction

  always_comb {gt0, eq0, lt0} = obs_fn(mode0, int'(a0), int'(b0), fault_tbl[{a0, b0}]);
  always_comb {gt1, eq1, lt1} = true_cmp(int'(a1), int'(b1));

  comparator_bist #(.WIDTH(2), .SETTLE(1)) u_dut0 (
    .clk(clk), .rst(rst0), .start(start0), .dut_a(a0), .dut_b(b0),
    .dut_gt(gt0), .dut_eq(eq0), .dut_lt(lt0),
    .busy(busy0), .done(done0), .pass(pass0), .err_count(err0)
`ifdef COMPARATOR_BIST_FAIL_LOG_EN
    , .fail_valid(fv0), .fail_a(fa0), .fail_b(fb0), .fail_obs(fo0)
`endif
  );

  comparator_bist #(.WIDTH(2), .SETTLE(3)) u_dut1 (
    .clk(clk), .rst(rst1), .start(start1), .dut_a(a1), .dut_b(b1),
    .dut_gt(gt1), .dut_eq(eq1), .dut_lt(lt1),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1)
`ifdef COMPARATOR_BIST_FAIL_LOG_EN
    , .fail_valid(fv1), .fail_a(fa1), .fail_b(fb1), .fail_obs(fo1)
`endif
  );

  // Reference sweep: A outer, B inner, count vectors whose outputs are wrong.
  task automatic model_sweep(input int mode, output int errs, output int fa, output int fb,
                             output logic [2:0] fo, output bit fv);
    logic [2:0] o;
    errs = 0; fa = 0; fb = 0; fo = 3'b000; fv = 1'b0;
    for (int a = 0; a < 4; a++) begin
      for (int b = 0; b < 4; b++) begin
        o = obs_fn(mode, a, b, fault_tbl[a * 4 + b]);
        if (o !== true_cmp(a, b)) begin
          errs++;
          if (!fv) begin
            fv = 1'b1; fa = a; fb = b; fo = o;
          end
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start0();
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
  endtask

  task automatic wait_done0(output int cyc);
    cyc = 0;
    while (done0 !== 1'b1 && cyc < 200) begin
      tick();
      cyc++;
    end
  endtask

  task automatic test_reset();
    rst0 = 1'b1; rst1 = 1'b1; start0 = 1'b1; start1 = 1'b0;
    tick(); tick();
    checks++; if (busy0 !== 1'b0) $display("FAIL reset_busy_with_start: got %b want 0", busy0); else passed++;
    start0 = 1'b0;
    tick();
    checks++; if ({a0, b0} !== 4'h0) $display("FAIL reset_ab: got %h want 0", {a0, b0}); else passed++;
    checks++; if ({busy0, done0, pass0} !== 3'b000) $display("FAIL reset_status: got %b want 000", {busy0, done0, pass0}); else passed++;
    checks++; if (err0 !== 5'd0) $display("FAIL reset_err: got %0d want 0", err0); else passed++;
    checks++; if ({busy1, done1, pass1, err1} !== 8'h00) $display("FAIL reset_dut1: got %h want 00", {busy1, done1, pass1, err1}); else passed++;
    rst0 = 1'b0; rst1 = 1'b0;
    tick();
  endtask

  task automatic test_sweep(input int mode, input string name);
    int cyc, errs, fa, fb;
    logic [2:0] fo;
    bit fv;
    mode0 = mode;
    model_sweep(mode, errs, fa, fb, fo, fv);
    pulse_start0();
    checks++; if (busy0 !== 1'b1 || {a0, b0} !== 4'h0) $display("FAIL %s_start: busy %b ab %h want 1/0", name, busy0, {a0, b0}); else passed++;
    wait_done0(cyc);
    checks++; if (cyc != 32) $display("FAIL %s_latency: got %0d want 32", name, cyc); else passed++;
    checks++; if (err0 !== 5'(errs)) $display("FAIL %s_err: got %0d want %0d", name, err0, errs); else passed++;
    checks++; if (pass0 !== (errs == 0)) $display("FAIL %s_pass: got %b want %b", name, pass0, errs == 0); else passed++;
    checks++; if (busy0 !== 1'b0) $display("FAIL %s_busy_after: got %b want 0", name, busy0); else passed++;
`ifdef COMPARATOR_BIST_FAIL_LOG_EN
    checks++; if (fv0 !== fv) $display("FAIL %s_fail_valid: got %b want %b", name, fv0, fv); else passed++;
    if (fv) begin
      checks++;
      if ({fa0, fb0, fo0} !== {2'(fa), 2'(fb), fo})
        $display("FAIL %s_fail_log: got a%0d b%0d o%b want a%0d b%0d o%b", name, fa0, fb0, fo0, fa, fb, fo);
      else passed++;
    end
`endif
  endtask

  task automatic test_fault_constants();
    int errs, fa, fb;
    logic [2:0] fo;
    bit fv;
    model_sweep(1, errs, fa, fb, fo, fv);
    test_sweep(1, "eq_stuck");
    checks++; if (err0 !== 5'd12) $display("FAIL eq_stuck_12: got %0d want 12", err0); else passed++;
    test_sweep(2, "gt_lt_swap");
    checks++; if (err0 !== 5'd12) $display("FAIL swap_12: got %0d want 12", err0); else passed++;
`ifdef COMPARATOR_BIST_FAIL_LOG_EN
    checks++;
    if ({fv0, fa0, fb0, fo0} !== {1'b1, 2'd0, 2'd1, 3'b100})
      $display("FAIL swap_first_fail: got %b want 1_00_01_100", {fv0, fa0, fb0, fo0});
    else passed++;
`endif
  endtask

  task automatic test_random_faults();
    for (int it = 0; it < 4; it++) begin
      for (int i = 0; i < 16; i++)
        fault_tbl[i] = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
      test_sweep(3, "random");
    end
    for (int i = 0; i < 16; i++) fault_tbl[i] = 3'b000;
  endtask

  task automatic test_reset_mid_sweep();
    int cyc;
    mode0 = 0;
    pulse_start0();
    repeat (9) tick();
    rst0 = 1'b1;
    tick();
    rst0 = 1'b0;
    checks++;
    if ({a0, b0, busy0, done0, pass0, err0} !== 12'h000)
      $display("FAIL mid_reset_outputs: got %h want 000", {a0, b0, busy0, done0, pass0, err0});
    else passed++;
    tick();
    checks++; if (busy0 !== 1'b0) $display("FAIL mid_reset_idle: busy %b want 0", busy0); else passed++;
    pulse_start0();
    wait_done0(cyc);
    checks++; if (cyc != 32 || pass0 !== 1'b1) $display("FAIL mid_reset_restart: cyc %0d pass %b want 32/1", cyc, pass0); else passed++;
  endtask

  task automatic test_start_ignored();
    int cyc;
    mode0 = 0;
    pulse_start0();
    repeat (7) tick();
    pulse_start0();
    wait_done0(cyc);
    checks++; if (cyc + 8 != 32) $display("FAIL start_ignored_latency: got %0d want 32", cyc + 8); else passed++;
    checks++; if (pass0 !== 1'b1) $display("FAIL start_ignored_pass: got %b want 1", pass0); else passed++;
  endtask

  task automatic test_back_to_back();
    int cyc;
    test_sweep(1, "b2b_first");
    repeat (3) tick();
    checks++; if (done0 !== 1'b1 || err0 !== 5'd12) $display("FAIL done_hold: done %b err %0d want 1/12", done0, err0); else passed++;
    pulse_start0();
    checks++;
    if ({done0, busy0, err0, a0, b0} !== {1'b0, 1'b1, 5'd0, 4'h0})
      $display("FAIL restart_clear: done %b busy %b err %0d ab %h want 0/1/0/0", done0, busy0, err0, {a0, b0});
    else passed++;
`ifdef COMPARATOR_BIST_FAIL_LOG_EN
    checks++; if (fv0 !== 1'b0) $display("FAIL restart_log_clear: got %b want 0", fv0); else passed++;
`endif
    wait_done0(cyc);
    checks++; if (cyc != 32 || err0 !== 5'd12 || pass0 !== 1'b0) $display("FAIL restart_repeat: cyc %0d err %0d pass %b want 32/12/0", cyc, err0, pass0); else passed++;
  endtask

  task automatic test_settle3();
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    for (int k = 0; k < 64; k++) begin
      checks++; if ({a1, b1} !== 4'(k / 4)) $display("FAIL settle3_vector k%0d: got %h want %h", k, {a1, b1}, k / 4); else passed++;
      if (k == 63) begin
        checks++; if (done1 !== 1'b0 || busy1 !== 1'b1) $display("FAIL settle3_early: done %b busy %b want 0/1", done1, busy1); else passed++;
      end
      tick();
    end
    checks++; if (done1 !== 1'b1) $display("FAIL settle3_done64: got %b want 1", done1); else passed++;
    checks++; if (pass1 !== 1'b1 || err1 !== 5'd0 || busy1 !== 1'b0) $display("FAIL settle3_result: pass %b err %0d busy %b want 1/0/0", pass1, err1, busy1); else passed++;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) fault_tbl[i] = 3'b000;
    mode0 = 0;
    rst0 = 1'b1; rst1 = 1'b1; start0 = 1'b0; start1 = 1'b0;
    test_reset();
    test_sweep(0, "correct");
    test_fault_constants();
    test_random_faults();
    test_reset_mid_sweep();
    test_start_ignored();
    test_back_to_back();
    test_settle3();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
